// File: rtl/cylon_pkg.sv
// Shared types and defaults for the cylon LED driver and its mode front-end.
package cylon_pkg;

    typedef enum logic [1:0] {
        CYLON  = 2'b00,
        R_TO_L = 2'b01,
        L_TO_R = 2'b10
    } mode_t;

    // 10 ms at 100 MHz
    localparam int DEBOUNCE_CYCLES_DEF = 1_000_000;

endpackage

// File: rtl/cylon_btn_if.sv
// Raw board button/switch bundle; the board drives it, the mode front-end samples it.
interface cylon_btn_if;

    logic       btnC;
    logic       btnL;
    logic       btnR;
    logic [2:0] sw;

    modport master (output btnC, output btnL, output btnR, output sw);
    modport slave  (input btnC, input btnL, input btnR, input sw);

endinterface

// File: rtl/cylon_debounce.sv
// Two-flop synchroniser plus debounce for one asynchronous button.
// Emits the accepted level and a single-cycle pulse on the edge it flips 0->1.
module cylon_debounce
    import cylon_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic stable_o,
    output logic rise_o
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             flip;

    always_comb begin
        sync1_d  = btn_raw;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        cnt_d    = '0;
        flip     = 1'b0;
        // counter only runs while the synced level disagrees with the accepted one
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                flip     = 1'b1;
                stable_d = ~stable_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    // combinational so the mode register can update on the same edge as the flip
    assign rise_o   = flip & ~stable_q;
    assign stable_o = stable_q;

endmodule

// File: rtl/cylon_mode_ctrl.sv
// Button/switch front-end producing a registered mode, a mode-change strobe and speed.
// Optional: define CYLON_MODE_TOGGLE_EN to let a repeat L/R press return to CYLON.
module cylon_mode_ctrl
    import cylon_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    cylon_btn_if.slave        btn,
    output logic [1:0]        mode,
    output logic              mode_stb,
    output logic [2:0]        speed
);

    logic [2:0] press;
    logic [2:0] stable_unused;

    mode_t      mode_q, mode_d;
    logic       mode_stb_q, mode_stb_d;
    logic [2:0] sw_s1_q, sw_s1_d;
    logic [2:0] sw_s2_q, sw_s2_d;

    cylon_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_c (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_raw  (btn.btnC),
        .stable_o (stable_unused[0]),
        .rise_o   (press[0])
    );

    cylon_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_l (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_raw  (btn.btnL),
        .stable_o (stable_unused[1]),
        .rise_o   (press[1])
    );

    cylon_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_r (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_raw  (btn.btnR),
        .stable_o (stable_unused[2]),
        .rise_o   (press[2])
    );

    // C beats R beats L; losing presses in the same cycle are dropped
    always_comb begin
        sw_s1_d = btn.sw;
        sw_s2_d = sw_s1_q;
        mode_d  = mode_q;
        if (press[0]) begin
            mode_d = CYLON;
        end else if (press[2]) begin
`ifdef CYLON_MODE_TOGGLE_EN
            if (mode_q == L_TO_R) mode_d = CYLON;
            else                  mode_d = L_TO_R;
`else
            mode_d = L_TO_R;
`endif
        end else if (press[1]) begin
`ifdef CYLON_MODE_TOGGLE_EN
            if (mode_q == R_TO_L) mode_d = CYLON;
            else                  mode_d = R_TO_L;
`else
            mode_d = R_TO_L;
`endif
        end
        mode_stb_d = (mode_d != mode_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q     <= CYLON;
            mode_stb_q <= 1'b0;
            sw_s1_q    <= 3'b000;
            sw_s2_q    <= 3'b000;
        end else begin
            mode_q     <= mode_d;
            mode_stb_q <= mode_stb_d;
            sw_s1_q    <= sw_s1_d;
            sw_s2_q    <= sw_s2_d;
        end
    end

    assign mode     = mode_q;
    assign mode_stb = mode_stb_q;
    assign speed    = sw_s2_q;

endmodule

// File: tb/tb_cylon_mode_ctrl.sv
// Bench for cylon_mode_ctrl: directed scenarios then random button activity,
// every cycle compared against a sliding-window reference model.
module tb_cylon_mode_ctrl;
    import cylon_pkg::*;

    localparam int D = 4;

`ifdef CYLON_MODE_TOGGLE_EN
    localparam bit TOGGLE_EN = 1'b1;
`else
    localparam bit TOGGLE_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] mode;
    logic       mode_stb;
    logic [2:0] speed;

    cylon_btn_if btn_if ();

    cylon_mode_ctrl #(.DEBOUNCE_CYCLES(D)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn      (btn_if),
        .mode     (mode),
        .mode_stb (mode_stb),
        .speed    (speed)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: samples taken at each rising edge, newest at the back.
    // A button's accepted level flips once the synced level (two samples late)
    // has disagreed with it for D consecutive edges.
    logic [5:0] hist[$];
    bit   [2:0] m_stable;
    int         m_mode;
    bit         m_stb;
    int         m_speed;

    function automatic logic [5:0] hget(input int back);
        if (hist.size() >= back) return hist[hist.size() - back];
        return 6'd0;
    endfunction

    always @(posedge clk or negedge rst_n) begin : model
        bit [2:0]   prs;
        bit         all_diff;
        int         nm;
        logic [5:0] s;
        if (!rst_n) begin
            hist.delete();
            m_stable = '0;
            m_mode   = 0;
            m_stb    = 1'b0;
            m_speed  = 0;
        end else begin
            for (int b = 0; b < 3; b++) begin
                all_diff = 1'b1;
                for (int j = 0; j < D; j++) begin
                    s = hget(2 + j);
                    if (s[b] == m_stable[b]) all_diff = 1'b0;
                end
                prs[b] = all_diff && !m_stable[b];
                if (all_diff) m_stable[b] = ~m_stable[b];
            end
            nm = m_mode;
            if (prs[0])      nm = 0;
            else if (prs[2]) nm = (TOGGLE_EN && m_mode == 2) ? 0 : 2;
            else if (prs[1]) nm = (TOGGLE_EN && m_mode == 1) ? 0 : 1;
            m_stb  = (nm != m_mode);
            m_mode = nm;
            s = hget(1);
            m_speed = int'(s[5:3]);
            hist.push_back({btn_if.sw, btn_if.btnR, btn_if.btnL, btn_if.btnC});
            if (hist.size() > 16) void'(hist.pop_front());
        end
    end

    always @(negedge clk) begin
        check("mode", mode, m_mode);
        check("mode_stb", mode_stb, m_stb);
        check("speed", speed, m_speed);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_btn(input bit c, input bit l, input bit r);
        btn_if.btnC = c;
        btn_if.btnL = l;
        btn_if.btnR = r;
    endtask

    // Reset asserted between edges; outputs must clear without waiting for a clock.
    task automatic do_reset();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mode", mode, 0);
        check("rst_stb", mode_stb, 0);
        check("rst_speed", speed, 0);
        tick(2);
        rst_n = 1'b1;
    endtask

    // Waits (bounded) for mode to reach want; latency counted in falling edges
    // from the drive point, plus the number of strobes seen in that window.
    task automatic wait_mode(input string tag, input logic [1:0] want, input int exp_lat);
        int lat = -1;
        int nstb = 0;
        for (int i = 1; i <= exp_lat + 8; i++) begin
            @(negedge clk);
            if (mode_stb) nstb++;
            if (lat < 0 && mode == want) lat = i;
        end
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_stb_count"}, nstb, 1);
    endtask

    initial begin
        set_btn(0, 0, 0);
        btn_if.sw = 3'b101;
        tick(3);
        rst_n = 1'b1;

        // 1: idle, speed follows sw after two edges
        tick(2);
        check("speed_sync", speed, 3'b101);
        tick(6);
        check("idle_mode", mode, 0);

        // 2: btnR held, mode L_TO_R after 1+D edges past the first sample
        set_btn(0, 0, 1);
        wait_mode("hold_r", 2'b10, D + 2);
        set_btn(0, 0, 0);
        tick(D + 4);

        // 3: short btnL glitch ignored, then a real press
        set_btn(0, 1, 0);
        tick(D - 1);
        set_btn(0, 0, 0);
        tick(D + 4);
        check("glitch_mode", mode, 2);
        set_btn(0, 1, 0);
        wait_mode("hold_l", 2'b01, D + 2);
        set_btn(0, 0, 0);
        tick(D + 4);

        // 4: simultaneous C/L/R: C wins
        set_btn(1, 1, 1);
        wait_mode("all_three", 2'b00, D + 2);
        set_btn(0, 0, 0);
        tick(D + 4);

        // 5: repeat press of the current mode's button
        set_btn(0, 0, 1);
        wait_mode("r_again_setup", 2'b10, D + 2);
        set_btn(0, 0, 0);
        tick(D + 4);
        set_btn(0, 0, 1);
        tick(D + 6);
        check("repeat_r_mode", mode, TOGGLE_EN ? 0 : 2);
        set_btn(0, 0, 0);
        tick(D + 4);

        // 6: reset mid-debounce with btnL still held
        set_btn(0, 1, 0);
        repeat (3) @(posedge clk);
        do_reset();
        wait_mode("post_reset_l", 2'b01, D + 2);
        set_btn(0, 0, 0);
        tick(D + 4);

        // random activity; toggles are sparse so many presses complete
        for (int i = 0; i < 2500; i++) begin
            @(negedge clk);
            if ($urandom_range(7) == 0) btn_if.btnC = ~btn_if.btnC;
            if ($urandom_range(7) == 0) btn_if.btnL = ~btn_if.btnL;
            if ($urandom_range(7) == 0) btn_if.btnR = ~btn_if.btnR;
            if ($urandom_range(31) == 0) btn_if.sw = 3'($urandom);
            if ($urandom_range(599) == 0) do_reset();
        end

        tick(2);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
